// File: rtl/parking_lot_fsm.sv
// ----------------------------------------------------------------------------
// parking_lot_fsm
// Gate controller and occupancy counter for a car park. Two light-barrier
// sensors (a = outer, b = inner) are synchronised into the clock domain and
// decoded by a sequence FSM into entry and exit events. A saturating counter
// tracks occupancy. Illegal sensor orderings park the FSM in ERR until both
// beams are clear again.
// ----------------------------------------------------------------------------
module parking_lot_fsm #(
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic             enter_pulse,
    output logic             exit_pulse,
    output logic             reject,
    output logic             err,
    output logic             full,
    output logic             empty
);

    // Gate sequence states. EN* walk the outer->inner order of an arriving
    // car, EX* the inner->outer order of a leaving car.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAPACITY);

    // Sensor patterns as seen on {a_s, b_s}.
    localparam logic [1:0] PAT_CLEAR = 2'b00;
    localparam logic [1:0] PAT_INNER = 2'b01;
    localparam logic [1:0] PAT_OUTER = 2'b10;
    localparam logic [1:0] PAT_BOTH  = 2'b11;

    // Two-flop synchronisers for the asynchronous sensor inputs.
    logic a_meta_r;
    logic a_sync_r;
    logic b_meta_r;
    logic b_sync_r;

    // FSM and output registers.
    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             enter_pulse_r;
    logic             exit_pulse_r;
    logic             reject_r;
    logic             err_r;

    // Combinational decode of the synchronised pattern.
    logic [1:0]       ab_s;
    state_t           next_state_s;
    logic             entry_evt_s;
    logic             exit_evt_s;
    logic             accept_entry_s;
    logic             accept_exit_s;
    logic             reject_evt_s;
    logic [CNT_W-1:0] next_count_s;

    assign ab_s = {a_sync_r, b_sync_r};

    // Synchronise both sensors through two flops; cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_meta_r <= 1'b0;
            a_sync_r <= 1'b0;
            b_meta_r <= 1'b0;
            b_sync_r <= 1'b0;
        end else begin
            a_meta_r <= a;
            a_sync_r <= a_meta_r;
            b_meta_r <= b;
            b_sync_r <= b_meta_r;
        end
    end

    // Next-state decode: listed patterns move, unlisted patterns hold, the
    // contradictory pattern of each state goes to ERR.
    always_comb begin
        next_state_s = state_r;
        entry_evt_s  = 1'b0;
        exit_evt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                case (ab_s)
                    PAT_OUTER: next_state_s = EN1;
                    PAT_INNER: next_state_s = EX1;
                    PAT_BOTH:  next_state_s = ERR;
                    default:   next_state_s = IDLE;
                endcase
            end
            EN1: begin
                case (ab_s)
                    PAT_BOTH:  next_state_s = EN2;
                    PAT_CLEAR: next_state_s = IDLE;   // car backed out
                    PAT_INNER: next_state_s = ERR;
                    default:   next_state_s = EN1;
                endcase
            end
            EN2: begin
                case (ab_s)
                    PAT_INNER: next_state_s = EN3;
                    PAT_OUTER: next_state_s = EN1;
                    PAT_CLEAR: next_state_s = ERR;
                    default:   next_state_s = EN2;
                endcase
            end
            EN3: begin
                case (ab_s)
                    PAT_BOTH:  next_state_s = EN2;
                    PAT_OUTER: next_state_s = ERR;
                    PAT_CLEAR: begin
                        next_state_s = IDLE;
                        entry_evt_s  = 1'b1;
                    end
                    default:   next_state_s = EN3;
                endcase
            end
            EX1: begin
                case (ab_s)
                    PAT_BOTH:  next_state_s = EX2;
                    PAT_CLEAR: next_state_s = IDLE;   // car backed in
                    PAT_OUTER: next_state_s = ERR;
                    default:   next_state_s = EX1;
                endcase
            end
            EX2: begin
                case (ab_s)
                    PAT_OUTER: next_state_s = EX3;
                    PAT_INNER: next_state_s = EX1;
                    PAT_CLEAR: next_state_s = ERR;
                    default:   next_state_s = EX2;
                endcase
            end
            EX3: begin
                case (ab_s)
                    PAT_BOTH:  next_state_s = EX2;
                    PAT_INNER: next_state_s = ERR;
                    PAT_CLEAR: begin
                        next_state_s = IDLE;
                        exit_evt_s   = 1'b1;
                    end
                    default:   next_state_s = EX3;
                endcase
            end
            ERR: begin
                if (ab_s == PAT_CLEAR) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ERR;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Resolve events against the current occupancy; the counter never wraps.
    always_comb begin
        accept_entry_s = 1'b0;
        accept_exit_s  = 1'b0;
        reject_evt_s   = 1'b0;
        next_count_s   = count_r;
        if (entry_evt_s) begin
            if (count_r < CNT_MAX) begin
                accept_entry_s = 1'b1;
                next_count_s   = count_r + CNT_ONE;
            end else begin
                reject_evt_s   = 1'b1;
            end
        end else if (exit_evt_s) begin
            if (count_r > CNT_ZERO) begin
                accept_exit_s  = 1'b1;
                next_count_s   = count_r - CNT_ONE;
            end else begin
                reject_evt_s   = 1'b1;
            end
        end else begin
            next_count_s   = count_r;
        end
    end

    // Gate FSM with registered count, pulses and error level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            count_r       <= CNT_ZERO;
            enter_pulse_r <= 1'b0;
            exit_pulse_r  <= 1'b0;
            reject_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            count_r       <= next_count_s;
            enter_pulse_r <= accept_entry_s;
            exit_pulse_r  <= accept_exit_s;
            reject_r      <= reject_evt_s;
            err_r         <= (next_state_s == ERR);
        end
    end

    assign count       = count_r;
    assign enter_pulse = enter_pulse_r;
    assign exit_pulse  = exit_pulse_r;
    assign reject      = reject_r;
    assign err         = err_r;
    // full/empty are decoded from the registered count.
    assign full        = (count_r == CNT_MAX);
    assign empty       = (count_r == CNT_ZERO);

endmodule
